// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode RAW hazard unit with stage forwarding, long-latency scoreboard and stall counter
module hazard_scoreboard #(
   parameter int XLEN    = 32,
   parameter int NUM_SRC = 2,
   parameter int NUM_STG = 3,
   parameter int MAX_LT  = 4,
   parameter int CNT_W   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC*5-1:0]    src_idx,
   input  logic [NUM_SRC-1:0]      src_used,
   input  logic                    dec_valid,
   input  logic [NUM_STG-1:0]      stg_valid,
   input  logic [NUM_STG*5-1:0]    stg_rd,
   input  logic [NUM_STG-1:0]      stg_data_ok,
   input  logic [NUM_STG*XLEN-1:0] stg_data,
   input  logic                    lt_issue,
   input  logic [4:0]              lt_issue_rd,
   input  logic                    lt_done,
   input  logic [4:0]              lt_done_rd,
   output logic                    stall_D,
   output logic                    lt_full,
   output logic [NUM_SRC-1:0]      fwd_valid,
   output logic [NUM_SRC*XLEN-1:0] fwd_data,
   output logic [CNT_W-1:0]        stall_cnt
);
   localparam int CW = $clog2(MAX_LT + 1);

   logic [31:0]        pend_q, pend_d, pend_vis;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [NUM_SRC-1:0] blocked;
   logic               hit, ok;
   logic [XLEN-1:0]    val;
   logic               issue_ok, done_ok;

   // Outstanding ops are not visible while reset flushes the LT unit
   assign pend_vis = rst ? '0 : pend_q;
   assign lt_full  = (cnt_q == CW'(MAX_LT));
   assign issue_ok = lt_issue & ~(lt_full & ~lt_done);
   assign done_ok  = lt_done & (cnt_q != '0);
   assign stall_D  = dec_valid & (|blocked);
   assign stall_cnt = stall_cnt_q;

   // Per source: youngest matching stage wins; otherwise a pending LT write blocks
   always_comb begin
      fwd_valid = '0;
      fwd_data  = '0;
      blocked   = '0;
      hit       = 1'b0;
      ok        = 1'b0;
      val       = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         hit = 1'b0;
         ok  = 1'b0;
         val = '0;
         for (int s = NUM_STG - 1; s >= 0; s--) begin
            if (src_used[i] && stg_valid[s] && (stg_rd[5*s +: 5] == src_idx[5*i +: 5]) && (src_idx[5*i +: 5] != 5'd0)) begin
               hit = 1'b1;
               ok  = stg_data_ok[s];
               val = stg_data[XLEN*s +: XLEN];
            end
         end
         fwd_valid[i]              = hit & ok;
         fwd_data[XLEN*i +: XLEN]  = (hit & ok) ? val : '0;
         blocked[i]                = hit ? ~ok : (src_used[i] & pend_vis[src_idx[5*i +: 5]]);
      end
   end

   // Scoreboard next state: a clear then a set, so a same-rd issue overrides the retire
   always_comb begin
      pend_d = pend_q;
      if (done_ok && lt_done_rd != 5'd0) pend_d[lt_done_rd] = 1'b0;
      if (issue_ok && lt_issue_rd != 5'd0) pend_d[lt_issue_rd] = 1'b1;
      pend_d[0] = 1'b0;
      cnt_d = cnt_q + CW'(issue_ok) - CW'(done_ok);
      stall_cnt_d = (stall_D && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= '0;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   a_issue_when_full: assert property (@(posedge clk) disable iff (rst) !(lt_issue && lt_full && !lt_done));
   a_done_when_empty: assert property (@(posedge clk) disable iff (rst) !(lt_done && cnt_q == '0));
endmodule
